// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, default timing and frame width.
// Used by the receiver and the transmit path.
package uart_pkg;

  localparam int unsigned UartClksPerBit = 434;
  localparam int unsigned UartDataW      = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StBreak  = 3'd5
  } uart_state_e;

  // Even parity: returns 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(logic [UartDataW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rcvr_if.sv
// Receiver result/status bundle: master drives it, slave (consumer) observes it.
interface uart_rcvr_if;
  import uart_pkg::*;

  logic [UartDataW-1:0] o_data;
  logic                 o_data_dv;
  logic                 o_busy;
  logic                 o_frame_err;
  logic                 o_false_start;
  logic                 o_parity_err;

  modport master (
    output o_data,
    output o_data_dv,
    output o_busy,
    output o_frame_err,
    output o_false_start,
    output o_parity_err
  );

  modport slave (
    input o_data,
    input o_data_dv,
    input o_busy,
    input o_frame_err,
    input o_false_start,
    input o_parity_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Generic multi-flop synchronizer for an asynchronous input; flops reset to 1
// so an idle-high line never looks like an edge coming out of reset.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rcvr.sv
// UART receiver, 8N1, LSB first, mid-bit sampling with a cycle counter.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rcvr
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UartClksPerBit,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  uart_rcvr_if.master rx_if
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntBit  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LastBit = 3'(UartDataW - 1);

  logic rx_s;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_rx),
    .o_q  (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [UartDataW-1:0] shreg_q, shreg_d;
  logic [UartDataW-1:0] data_q, data_d;
  logic                 dv_q, dv_d;
  logic                 ferr_q, ferr_d;
  logic                 fs_q, fs_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_bad_q, par_bad_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    ferr_d    = ferr_q;
    fs_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = perr_q;
    par_bad_d = par_bad_q;
`endif

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
            fs_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == CntBit) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[UartDataW-1:1]};
          if (bit_idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntBit) begin
          cnt_d     = '0;
          par_bad_d = even_parity(shreg_q) ^ rx_s;
          if (par_bad_d) begin
            perr_d = 1'b1;
          end
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif

      // Leaves at mid-stop-bit so a start edge right after the stop bit is caught.
      StStop: begin
        if (cnt_q == CntBit) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            dv_d    = 1'b1;
            ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StBreak: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      fs_q      <= fs_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
    end
  end

  assign rx_if.o_parity_err = perr_q;
`else
  assign rx_if.o_parity_err = 1'b0;
`endif

  assign rx_if.o_data        = data_q;
  assign rx_if.o_data_dv     = dv_q;
  assign rx_if.o_busy        = (state_q != StIdle);
  assign rx_if.o_frame_err   = ferr_q;
  assign rx_if.o_false_start = fs_q;

endmodule

// File: tb/tb_uart_rcvr.sv
// Self-checking bench for uart_rcvr: serial frames are generated here, expected
// bytes are queued on send and popped by a monitor on each data-valid pulse.
module tb_uart_rcvr;
  import uart_pkg::*;

  localparam int unsigned CPB  = 434;
  localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned LAT = SYNC + CPB / 2 + (NBITS - 1) * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int unsigned cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rcvr_if rx_if ();

  uart_rcvr #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx (rx),
    .rx_if(rx_if)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int unsigned dv_cyc_q[$];
  int unsigned fs_count = 0;
  int unsigned fs_cyc = 0;
  logic [7:0]  model_data = 8'h00;
  logic [7:0]  mon_exp;

  always @(negedge clk) begin
    if (rx_if.o_false_start === 1'b1) begin
      fs_count++;
      fs_cyc = cyc;
    end
    if (rx_if.o_data_dv === 1'b1) begin
      dv_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dv: got data %h, required no dv", rx_if.o_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_if.o_data !== mon_exp) begin
          errors++;
          $display("FAIL dv_data: got %h, required %h", rx_if.o_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic hold(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now; queues the byte when the stop bit is good.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input int unsigned cpb, output int unsigned t_fall);
    if (stop_bit) begin
      exp_q.push_back(b);
      model_data = b;
    end
    t_fall = cyc;
    rx = 1'b0;
    hold(cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(cpb);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    hold(cpb);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    rx = stop_bit;
    hold(cpb);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (rx_if.o_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", rx_if.o_data); end
    if (rx_if.o_data_dv !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b, required 0", rx_if.o_data_dv); end
    if (rx_if.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", rx_if.o_busy); end
    if (rx_if.o_frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b, required 0", rx_if.o_frame_err); end
    if (rx_if.o_false_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b, required 0", rx_if.o_false_start); end
    if (rx_if.o_parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b, required 0", rx_if.o_parity_err); end
    rst = 1'b0;
    hold(10);
    checks++;
    if (fs_count != 0) begin errors++; $display("FAIL rst_no_fs: got %0d false starts, required 0", fs_count); end
  endtask

  task automatic test_single();
    int unsigned t0, n0, fs0, lat;
    align();
    n0 = dv_cyc_q.size();
    fs0 = fs_count;
    send_frame(8'h55, 1'b1, 1'b0, CPB, t0);
    wait_drain(100);
    lat = (dv_cyc_q.size() == n0 + 1) ? dv_cyc_q[n0] - t0 : 0;
    checks += 4;
    if (lat < LAT - 2 || lat > LAT + 2) begin errors++; $display("FAIL single_latency: got %0d, required %0d+-2", lat, LAT); end
    if (rx_if.o_data !== 8'h55) begin errors++; $display("FAIL single_data: got %h, required 55", rx_if.o_data); end
    if (rx_if.o_frame_err !== 1'b0) begin errors++; $display("FAIL single_ferr: got %b, required 0", rx_if.o_frame_err); end
    if (fs_count != fs0) begin errors++; $display("FAIL single_fs: got %0d, required %0d", fs_count, fs0); end
  endtask

  task automatic test_back_to_back();
    int unsigned t0, n0, fs0, d1, d2;
    align();
    n0 = dv_cyc_q.size();
    fs0 = fs_count;
    send_frame(8'hA3, 1'b1, 1'b0, CPB, t0);
    send_frame(8'h00, 1'b1, 1'b0, CPB, t0);
    send_frame(8'hFF, 1'b1, 1'b0, CPB, t0);
    wait_drain(100);
    checks++;
    if (dv_cyc_q.size() != n0 + 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d dv, required 3", dv_cyc_q.size() - n0);
    end else begin
      d1 = dv_cyc_q[n0 + 1] - dv_cyc_q[n0];
      d2 = dv_cyc_q[n0 + 2] - dv_cyc_q[n0 + 1];
      checks += 2;
      if (d1 < NBITS * CPB - 2 || d1 > NBITS * CPB + 2) begin errors++; $display("FAIL b2b_gap1: got %0d, required %0d", d1, NBITS * CPB); end
      if (d2 < NBITS * CPB - 2 || d2 > NBITS * CPB + 2) begin errors++; $display("FAIL b2b_gap2: got %0d, required %0d", d2, NBITS * CPB); end
    end
    checks += 2;
    if (rx_if.o_frame_err !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b, required 0", rx_if.o_frame_err); end
    if (fs_count != fs0) begin errors++; $display("FAIL b2b_fs: got %0d, required %0d", fs_count, fs0); end
  endtask

  task automatic test_false_start();
    int unsigned t0, n0, fs0, k, dt;
    align();
    n0 = dv_cyc_q.size();
    fs0 = fs_count;
    t0 = cyc;
    rx = 1'b0;
    hold(100);
    rx = 1'b1;
    k = 0;
    while (fs_count == fs0 && k < 600) begin
      @(negedge clk);
      k++;
    end
    hold(CPB);
    @(negedge clk);
    dt = fs_cyc - t0;
    checks += 4;
    if (fs_count != fs0 + 1) begin errors++; $display("FAIL fs_count: got %0d, required %0d", fs_count, fs0 + 1); end
    if (dt < 216 || dt > 222) begin errors++; $display("FAIL fs_time: got %0d, required ~219", dt); end
    if (dv_cyc_q.size() != n0) begin errors++; $display("FAIL fs_no_dv: got %0d dv, required 0", dv_cyc_q.size() - n0); end
    if (rx_if.o_busy !== 1'b0) begin errors++; $display("FAIL fs_busy: got %b, required 0", rx_if.o_busy); end
  endtask

  task automatic test_frame_error();
    int unsigned t0, n0;
    logic [7:0] d0;
    align();
    n0 = dv_cyc_q.size();
    d0 = model_data;
    send_frame(8'h3C, 1'b0, 1'b0, CPB, t0);
    hold(2000);
    @(negedge clk);
    checks += 4;
    if (rx_if.o_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b, required 1", rx_if.o_frame_err); end
    if (rx_if.o_busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy: got %b, required 1", rx_if.o_busy); end
    if (rx_if.o_data !== d0) begin errors++; $display("FAIL ferr_data_hold: got %h, required %h", rx_if.o_data, d0); end
    if (dv_cyc_q.size() != n0) begin errors++; $display("FAIL ferr_no_dv: got %0d dv, required 0", dv_cyc_q.size() - n0); end
    align();
    rx = 1'b1;
    hold(20);
    checks += 2;
    if (rx_if.o_busy !== 1'b0) begin errors++; $display("FAIL ferr_idle: got busy %b, required 0", rx_if.o_busy); end
    if (rx_if.o_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b, required 1", rx_if.o_frame_err); end
    send_frame(8'h81, 1'b1, 1'b0, CPB, t0);
    wait_drain(100);
    checks += 2;
    if (rx_if.o_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b, required 0", rx_if.o_frame_err); end
    if (rx_if.o_data !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h, required 81", rx_if.o_data); end
  endtask

  task automatic test_reset_mid_frame();
    int unsigned t0, n0;
    logic [7:0] b;
    b = 8'h7E;
    align();
    n0 = dv_cyc_q.size();
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      hold(CPB);
    end
    rx = b[4];
    hold(200);
    #2;
    rst = 1'b1;
    #1;
    checks += 3;
    if (rx_if.o_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h, required 00", rx_if.o_data); end
    if (rx_if.o_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", rx_if.o_busy); end
    if (rx_if.o_frame_err !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr: got %b, required 0", rx_if.o_frame_err); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    model_data = 8'h00;
    hold(12 * CPB);
    checks += 2;
    if (dv_cyc_q.size() != n0) begin errors++; $display("FAIL mid_rst_no_dv: got %0d dv, required 0", dv_cyc_q.size() - n0); end
    if (rx_if.o_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data_after: got %h, required 00", rx_if.o_data); end
    send_frame(8'h12, 1'b1, 1'b0, CPB, t0);
    wait_drain(100);
    checks++;
    if (rx_if.o_data !== 8'h12) begin errors++; $display("FAIL mid_rst_next: got %h, required 12", rx_if.o_data); end
  endtask

  task automatic test_baud_tolerance();
    int unsigned t0;
    align();
    send_frame(8'hC5, 1'b1, 1'b0, (CPB * 103) / 100, t0);
    wait_drain(200);
    checks++;
    if (rx_if.o_data !== 8'hC5) begin errors++; $display("FAIL baud_slow: got %h, required C5", rx_if.o_data); end
    hold(CPB);
    send_frame(8'h2B, 1'b1, 1'b0, (CPB * 97) / 100, t0);
    wait_drain(200);
    checks += 2;
    if (rx_if.o_data !== 8'h2B) begin errors++; $display("FAIL baud_fast: got %h, required 2B", rx_if.o_data); end
    if (rx_if.o_frame_err !== 1'b0) begin errors++; $display("FAIL baud_ferr: got %b, required 0", rx_if.o_frame_err); end
  endtask

  task automatic test_parity();
    int unsigned t0;
    align();
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, CPB, t0);
    wait_drain(100);
    checks += 2;
    if (rx_if.o_parity_err !== 1'b1) begin errors++; $display("FAIL par_set: got %b, required 1", rx_if.o_parity_err); end
    if (rx_if.o_data !== 8'h07) begin errors++; $display("FAIL par_data: got %h, required 07", rx_if.o_data); end
    send_frame(8'h07, 1'b1, 1'b0, CPB, t0);
    wait_drain(100);
    checks++;
    if (rx_if.o_parity_err !== 1'b0) begin errors++; $display("FAIL par_clear: got %b, required 0", rx_if.o_parity_err); end
`else
    send_frame(8'h6D, 1'b1, 1'b0, CPB, t0);
    wait_drain(100);
    checks += 2;
    if (rx_if.o_parity_err !== 1'b0) begin errors++; $display("FAIL par_tied: got %b, required 0", rx_if.o_parity_err); end
    if (rx_if.o_data !== 8'h6D) begin errors++; $display("FAIL par_off_data: got %h, required 6D", rx_if.o_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_parity();
    hold(10);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: got %0d pending, required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
